// File: rtl/nes_timing_pkg.sv
// nes_timing_pkg: scheduler state type, default dividers and divider legality check
package nes_timing_pkg;
  typedef enum logic [1:0] {HALTED, RUNNING, STEPPING} sched_state_t;
  localparam int PPU_DIV_DEF = 4;
  localparam int CPU_DIV_DEF = 12;
  function automatic bit div_legal(int ppu_div, int cpu_div);
    return ppu_div >= 1 && cpu_div >= 2 && cpu_div % ppu_div == 0;
  endfunction
endpackage

// File: rtl/ce_counter.sv
// ce_counter: wrapping 0..N-1 phase counter with hold and terminal-count flag
module ce_counter #(
  parameter int N = 12,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         hold,
  output logic [W-1:0] cnt,
  output logic         tc
);
  localparam logic [W-1:0] LAST = W'(N - 1);
  assign tc = cnt == LAST;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (!hold) cnt <= tc ? '0 : cnt + 1'b1;
endmodule

// File: rtl/clk_enable_sched.sv
// clk_enable_sched: master-clock PPU/CPU enable strobes with run/halt/step sequencing
module clk_enable_sched
  import nes_timing_pkg::*;
#(
  parameter int PPU_DIV   = PPU_DIV_DEF,
  parameter int CPU_DIV   = CPU_DIV_DEF,
  parameter bit START_RUN = 1'b1,
  parameter int CNT_W     = 32
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             run,
  input  logic             step,
  input  logic             clr_cnt,
  output logic             ppu_ce,
  output logic             cpu_ce,
  output logic             m2,
  output logic             halted,
  output logic [CNT_W-1:0] cpu_cycles
);
  localparam int W = $clog2(CPU_DIV);
  localparam logic [W:0] PPU_M = (W+1)'(PPU_DIV);
  localparam logic [W-1:0] HALF = W'(CPU_DIV / 2);
  localparam sched_state_t RST_ST = START_RUN ? RUNNING : HALTED;
  if (!div_legal(PPU_DIV, CPU_DIV)) begin : g_bad_div
    $error("clk_enable_sched: illegal PPU_DIV/CPU_DIV combination");
  end
  sched_state_t state, nxt;
  logic [W-1:0] mcnt;
  logic tc, active;
  ce_counter #(.N(CPU_DIV)) u_phase (
    .clk(Clk),
    .rst_n(Reset_n),
    .hold(state == HALTED),
    .cnt(mcnt),
    .tc(tc)
  );
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) state <= RST_ST;
    else state <= nxt;
  // leaving RUNNING/STEPPING only happens on the last phase, so cycles are never cut short
  always_comb begin
    nxt = state;
    if (state == HALTED) nxt = run ? RUNNING : step ? STEPPING : HALTED;
    else if (tc) nxt = run ? RUNNING : HALTED;
  end
  // Reset_n gating keeps every output quiet while reset is held
  assign active = Reset_n && state != HALTED;
  assign cpu_ce = active && mcnt == '0;
  assign ppu_ce = active && {1'b0, mcnt} % PPU_M == '0;
  assign m2     = active && mcnt >= HALF;
  assign halted = Reset_n && state == HALTED;
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) cpu_cycles <= '0;
    else if (clr_cnt) cpu_cycles <= '0;
    else if (cpu_ce) cpu_cycles <= cpu_cycles + 1'b1;
endmodule

// File: tb/tb_clk_enable_sched.sv
// tb_clk_enable_sched: scoreboarded cpu_ce checks plus directed state/count checks
module tb_clk_enable_sched;
  typedef struct {int cyc; int cnt;} exp_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_na, run_a, step_a, clr_a, ppu_a, cpu_a, m2_a, halt_a;
  logic [31:0] cnt_a;
  logic rst_nb, run_b, step_b, clr_b, ppu_b, cpu_b, m2_b, halt_b;
  logic [3:0] cnt_b;
  clk_enable_sched #(.PPU_DIV(4), .CPU_DIV(12), .START_RUN(1'b1), .CNT_W(32)) dut_a (
    .Clk(clk), .Reset_n(rst_na), .run(run_a), .step(step_a), .clr_cnt(clr_a),
    .ppu_ce(ppu_a), .cpu_ce(cpu_a), .m2(m2_a), .halted(halt_a), .cpu_cycles(cnt_a)
  );
  clk_enable_sched #(.PPU_DIV(4), .CPU_DIV(12), .START_RUN(1'b0), .CNT_W(4)) dut_b (
    .Clk(clk), .Reset_n(rst_nb), .run(run_b), .step(step_b), .clr_cnt(clr_b),
    .ppu_ce(ppu_b), .cpu_ce(cpu_b), .m2(m2_b), .halted(halt_b), .cpu_cycles(cnt_b)
  );
  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;
  exp_t qa[$], qb[$];
  int mon_total = 0, mon_bad = 0, st_total = 0, st_bad = 0;
  int pa = 0, ma = 0;
  always @(negedge clk) begin
    exp_t e;
    if (ppu_a) pa = pa + 1;
    if (m2_a) ma = ma + 1;
    if (cpu_a) begin
      mon_total = mon_total + 1;
      if (qa.size() == 0) begin
        mon_bad = mon_bad + 1;
        $display("FAIL cpu_ce_a: unexpected strobe at cyc=%0d cnt=%0d", cyc, cnt_a);
      end else begin
        e = qa.pop_front();
        if (e.cyc != cyc || e.cnt != int'(cnt_a)) begin
          mon_bad = mon_bad + 1;
          $display("FAIL cpu_ce_a: got cyc=%0d cnt=%0d want cyc=%0d cnt=%0d", cyc, cnt_a, e.cyc, e.cnt);
        end
      end
    end
    if (cpu_b) begin
      mon_total = mon_total + 1;
      if (qb.size() == 0) begin
        mon_bad = mon_bad + 1;
        $display("FAIL cpu_ce_b: unexpected strobe at cyc=%0d cnt=%0d", cyc, cnt_b);
      end else begin
        e = qb.pop_front();
        if (e.cyc != cyc || e.cnt != int'(cnt_b)) begin
          mon_bad = mon_bad + 1;
          $display("FAIL cpu_ce_b: got cyc=%0d cnt=%0d want cyc=%0d cnt=%0d", cyc, cnt_b, e.cyc, e.cnt);
        end
      end
    end
  end
  task automatic chk(input string name, input int act, input int exp);
    st_total = st_total + 1;
    if (act != exp) begin
      st_bad = st_bad + 1;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic push_a(input int c, input int n);
    exp_t e;
    e.cyc = c;
    e.cnt = n;
    qa.push_back(e);
  endtask
  task automatic push_b(input int c, input int n);
    exp_t e;
    e.cyc = c;
    e.cnt = n;
    qb.push_back(e);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached at cyc=%0d", cyc);
    $fatal(1);
  end
  initial begin
    int s, p, m;
    rst_na = 1'b0; run_a = 1'b1; step_a = 1'b0; clr_a = 1'b0;
    rst_nb = 1'b0; run_b = 1'b0; step_b = 1'b0; clr_b = 1'b0;
    tick(3);
    chk("rst_cpu_ce", int'(cpu_a), 0);
    chk("rst_ppu_ce", int'(ppu_a), 0);
    chk("rst_m2", int'(m2_a), 0);
    chk("rst_halted_a", int'(halt_a), 0);
    chk("rst_halted_b", int'(halt_b), 0);
    chk("rst_cnt", int'(cnt_a), 0);
    rst_na = 1'b1;
    s = cyc;
    for (int k = 0; k < 5; k++) push_a(s + 12 * k, k);
    p = pa;
    tick(48);
    chk("run48_cnt", int'(cnt_a), 4);
    chk("run48_ppu", pa - p, 12);
    p = pa;
    tick(3);
    run_a = 1'b0;
    tick(8);
    chk("halt_pending", int'(halt_a), 0);
    tick(1);
    chk("halt_rise", int'(halt_a), 1);
    chk("halt_cnt", int'(cnt_a), 5);
    chk("halt_ppu", pa - p, 3);
    tick(24);
    chk("halt_hold", int'(halt_a), 1);
    chk("halt_frozen", int'(cnt_a), 5);
    chk("halt_no_ppu", pa - p, 3);
    p = pa; m = ma; s = cyc;
    push_a(s + 1, 5);
    step_a = 1'b1;
    tick(1);
    step_a = 1'b0;
    tick(11);
    chk("step_busy", int'(halt_a), 0);
    tick(1);
    chk("step_done", int'(halt_a), 1);
    chk("step_cnt", int'(cnt_a), 6);
    chk("step_ppu", pa - p, 3);
    chk("step_m2", ma - m, 6);
    s = cyc;
    for (int k = 0; k < 3; k++) push_a(s + 1 + 12 * k, 6 + k);
    run_a = 1'b1; step_a = 1'b1;
    tick(1);
    step_a = 1'b0;
    tick(24);
    run_a = 1'b0;
    tick(11);
    chk("runstep_busy", int'(halt_a), 0);
    tick(1);
    chk("runstep_halt", int'(halt_a), 1);
    tick(24);
    chk("runstep_no_step", int'(halt_a), 1);
    chk("runstep_cnt", int'(cnt_a), 9);
    s = cyc;
    push_a(s + 1, 9);
    run_a = 1'b1;
    tick(1);
    clr_a = 1'b1; run_a = 1'b0;
    tick(1);
    clr_a = 1'b0;
    chk("clr_wins", int'(cnt_a), 0);
    tick(11);
    chk("clr_halt", int'(halt_a), 1);
    chk("clr_hold", int'(cnt_a), 0);
    s = cyc;
    push_a(s + 1, 0);
    run_a = 1'b1;
    tick(6);
    rst_na = 1'b0;
    run_a = 1'b0;
    #1;
    chk("midrst_cnt", int'(cnt_a), 0);
    chk("midrst_cpu_ce", int'(cpu_a), 0);
    chk("midrst_ppu_ce", int'(ppu_a), 0);
    chk("midrst_m2", int'(m2_a), 0);
    chk("midrst_halted", int'(halt_a), 0);
    tick(1);
    rst_nb = 1'b1;
    tick(10);
    chk("b_halted", int'(halt_b), 1);
    chk("b_cnt0", int'(cnt_b), 0);
    s = cyc;
    for (int k = 0; k < 16; k++) push_b(s + 1 + 12 * k, k);
    run_b = 1'b1;
    tick(181);
    run_b = 1'b0;
    tick(11);
    chk("b_busy", int'(halt_b), 0);
    tick(1);
    chk("b_halt", int'(halt_b), 1);
    chk("b_wrap", int'(cnt_b), 0);
    tick(5);
    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    $display("test done: total=%0d bad=%0d", st_total + mon_total, st_bad + mon_bad);
    $finish;
  end
endmodule
